// File: rtl/rewire_out_word_packer.sv
// Packs the ReWire byte stream into 32-bit words and buffers them in a small FIFO.
// The byte side cannot stall, so words that find the FIFO full are dropped and counted.
module rewire_out_word_packer #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [2:0]       out_bytes,
  output logic [CNT_W-1:0] drop_count,
  output logic             overflow,
  input  logic             clear_drop
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_OCC = (AW+1)'(FIFO_DEPTH);

  logic [1:0]       lane_cnt_q, lane_cnt_d;
  logic [23:0]      lane_q, lane_d;
  logic             push;
  logic [31:0]      push_data;
  logic [2:0]       push_bytes;

  logic [34:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      occ_q, occ_d;
  logic             pop, full, accept, drop;
  logic [34:0]      head;

  logic [CNT_W-1:0] drop_count_q, drop_count_d;
  logic             overflow_q, overflow_d;

  // Lanes above the counter are always zero, so OR-ing the new byte in is enough.
  always_comb begin
    lane_cnt_d = lane_cnt_q;
    lane_d     = lane_q;
    push       = 1'b0;
    push_data  = {8'h00, lane_q};
    push_bytes = {1'b0, lane_cnt_q};
    if (in_valid) begin
      push_data  = {8'h00, lane_q} | ({24'h000000, in_data} << {lane_cnt_q, 3'b000});
      push_bytes = {1'b0, lane_cnt_q} + 3'd1;
      if (lane_cnt_q == 2'd3 || flush) begin
        push       = 1'b1;
        lane_cnt_d = 2'd0;
        lane_d     = 24'h000000;
      end else begin
        lane_cnt_d = lane_cnt_q + 2'd1;
        lane_d     = push_data[23:0];
      end
    end else if (flush && lane_cnt_q != 2'd0) begin
      push       = 1'b1;
      lane_cnt_d = 2'd0;
      lane_d     = 24'h000000;
    end
  end

  assign pop    = (occ_q != '0) && out_ready;
  assign full   = (occ_q == DEPTH_OCC);
  assign accept = push && (!full || pop);
  assign drop   = push && full && !pop;

  always_comb begin
    occ_d = occ_q;
    case ({accept, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  // Clearing in the same cycle as a drop still records that drop.
  always_comb begin
    drop_count_d = drop_count_q;
    overflow_d   = overflow_q;
    if (clear_drop) begin
      drop_count_d = {{(CNT_W-1){1'b0}}, drop};
      overflow_d   = drop;
    end else if (drop) begin
      if (!(&drop_count_q)) drop_count_d = drop_count_q + 1'b1;
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_cnt_q   <= 2'd0;
      lane_q       <= 24'h000000;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      occ_q        <= '0;
      drop_count_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      lane_cnt_q   <= lane_cnt_d;
      lane_q       <= lane_d;
      occ_q        <= occ_d;
      drop_count_q <= drop_count_d;
      overflow_q   <= overflow_d;
      if (accept) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)    rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q] <= {push_bytes, push_data};
  end

  assign head       = mem_q[rd_ptr_q];
  assign out_valid  = (occ_q != '0);
  assign out_data   = out_valid ? head[31:0]  : 32'h00000000;
  assign out_bytes  = out_valid ? head[34:32] : 3'd0;
  assign drop_count = drop_count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_rewire_out_word_packer.sv
// Randomized and directed bench for rewire_out_word_packer against a queue-based model.
module tb_rewire_out_word_packer;

  localparam int DEPTH  = 4;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, flush, out_ready, clear_drop;
  logic [7:0]       in_data;
  logic             out_valid, overflow;
  logic [31:0]      out_data;
  logic [2:0]       out_bytes;
  logic [CNT_W-1:0] drop_count;

  rewire_out_word_packer #(.FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_bytes(out_bytes), .drop_count(drop_count), .overflow(overflow),
    .clear_drop(clear_drop)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  byte_q[$];
  logic [34:0] fifo_q[$];
  int          m_drop;
  bit          m_ovf;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    byte_q.delete();
    fifo_q.delete();
    m_drop = 0;
    m_ovf  = 1'b0;
  endtask

  task automatic model_cycle(input bit v, input logic [7:0] d, input bit f, input bit r, input bit c);
    bit          do_push, do_drop;
    logic [34:0] w;
    logic [31:0] data;
    do_push = 1'b0;
    do_drop = 1'b0;
    data    = 32'h0;
    if (v) byte_q.push_back(d);
    if (byte_q.size() == 4 || (f && byte_q.size() > 0)) begin
      for (int i = 0; i < byte_q.size(); i++) data = data + (32'(byte_q[i]) << (8 * i));
      w = {3'(byte_q.size()), data};
      byte_q.delete();
      do_push = 1'b1;
    end
    if (r && fifo_q.size() > 0) void'(fifo_q.pop_front());
    if (do_push) begin
      if (fifo_q.size() < DEPTH) fifo_q.push_back(w);
      else do_drop = 1'b1;
    end
    if (c) begin
      m_drop = do_drop ? 1 : 0;
      m_ovf  = do_drop;
    end else if (do_drop) begin
      if (m_drop < CNT_MAX) m_drop++;
      m_ovf = 1'b1;
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [34:0] h;
    h = (fifo_q.size() > 0) ? fifo_q[0] : 35'h0;
    check({tag, ".valid"}, 64'(out_valid),  64'(fifo_q.size() > 0));
    check({tag, ".data"},  64'(out_data),   64'(h[31:0]));
    check({tag, ".bytes"}, 64'(out_bytes),  64'(h[34:32]));
    check({tag, ".drops"}, 64'(drop_count), 64'(m_drop));
    check({tag, ".ovf"},   64'(overflow),   64'(m_ovf));
  endtask

  task automatic step(input bit v, input logic [7:0] d, input bit f, input bit r, input bit c);
    in_valid   = v;
    in_data    = d;
    flush      = f;
    out_ready  = r;
    clear_drop = c;
    @(posedge clk);
    model_cycle(v, d, f, r, c);
    #1;
    check_outputs("cyc");
  endtask

  task automatic do_reset();
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; clear_drop = 1'b0; in_data = 8'h00;
    rst = 1'b1;
    #1;
    model_clear();
    check("rst.valid", 64'(out_valid), 64'd0);
    check("rst.drops", 64'(drop_count), 64'd0);
    check_outputs("rst");
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; clear_drop = 1'b0; in_data = 8'h00;
    model_clear();
    #1;
    check_outputs("init");
    #6;
    rst = 1'b0;

    // 1: streaming full words
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b1, 1'b0);
      if (i == 4) check("t1.w0", 64'(out_data), 64'h04030201);
      if (i == 8) check("t1.w1", 64'(out_data), 64'h08070605);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check("t1.drops", 64'(drop_count), 64'd0);

    // 2: partial flush, then flush coinciding with the completing byte
    step(1'b1, 8'hAA, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'hBB, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'hCC, 1'b0, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    check("t2.part", 64'({out_bytes, out_data}), 64'({3'd3, 32'h00CCBBAA}));
    step(1'b1, 8'hAA, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'hBB, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'hCC, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'hDD, 1'b1, 1'b1, 1'b0);
    check("t2.full", 64'({out_bytes, out_data}), 64'({3'd4, 32'hDDCCBBAA}));
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check("t2.single", 64'(out_valid), 64'd0);

    // 3: overflow with consumer stalled, then drain
    for (int i = 0; i < 20; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    check("t3.drops", 64'(drop_count), 64'd1);
    check("t3.ovf", 64'(overflow), 64'd1);
    check("t3.head", 64'(out_data), 64'h03020100);
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check("t3.empty", 64'(out_valid), 64'd0);

    // 4: pop on the exact cycle a push meets a full FIFO
    do_reset();
    for (int i = 0; i < 19; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'd19, 1'b0, 1'b1, 1'b0);
    check("t4.nodrop", 64'(drop_count), 64'd0);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check("t4.last", 64'(out_valid), 64'd0);

    // 5: clear_drop, clear coinciding with a drop, saturation
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 8'hE0, 1'b1, 1'b0, 1'b0);
    check("t5.three", 64'(drop_count), 64'd3);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("t5.clr", 64'({overflow, drop_count}), 64'd0);
    step(1'b1, 8'hE1, 1'b1, 1'b0, 1'b1);
    check("t5.clrdrop", 64'({overflow, drop_count}), 64'({1'b1, 4'd1}));
    for (int i = 0; i < 20; i++) step(1'b1, 8'hE2, 1'b1, 1'b0, 1'b0);
    check("t5.sat", 64'(drop_count), 64'(CNT_MAX));

    // 6: reset with a partial word and buffered words
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
    do_reset();
    step(1'b1, 8'h11, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'h12, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'h13, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'h14, 1'b0, 1'b1, 1'b0);
    check("t6.word", 64'({out_bytes, out_data}), 64'({3'd4, 32'h14131211}));

    // random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 9) != 0), 8'($urandom), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 1) == 1), ($urandom_range(0, 29) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
